// File: rtl/data_mem_responder.sv
// Word-addressed scratchpad with valid/ready request and response channels; response WAIT_CYCLES+1 cycles after accept,
// held stable until rsp_ready, one access in flight. `DMR_ERR_EN enables range/alignment error reporting.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            live_q, live_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH];

  logic [31:0]     off;
  logic [AW-1:0]   req_idx;
  logic            req_err;
  logic            unused_addr_bits;
  logic            accept, enter_resp, mem_we;
  logic            tx_we, tx_err;
  logic [AW-1:0]   tx_idx;
  logic [31:0]     tx_wdata;

  assign off     = req_addr - BASE_ADDR;
  assign req_idx = off[AW+1:2];

`ifdef DMR_ERR_EN
  assign req_err          = (off[31:AW+2] != '0) || (req_addr[1:0] != 2'b00);
  assign unused_addr_bits = ^off[1:0];
`else
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{off[31:AW+2], off[1:0]};
`endif

  // live_q keeps req_ready low until the first edge after reset is released
  assign req_ready = live_q && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    live_d     = 1'b1;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rsp_err_d  = rsp_err_q;
    enter_resp = 1'b0;
    tx_we      = we_q;
    tx_idx     = idx_q;
    tx_wdata   = wdata_q;
    tx_err     = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          idx_d    = req_idx;
          wdata_d  = req_wdata;
          err_d    = req_err;
          // with zero wait states the access completes straight from the live request
          tx_we    = req_we;
          tx_idx   = req_idx;
          tx_wdata = req_wdata;
          tx_err   = req_err;
          cnt_d    = '0;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      rsp_err_d = tx_err;
      if (tx_we)       rdata_d = '0;
      else if (tx_err) rdata_d = 32'hDEAD_BEEF;
      else             rdata_d = mem[tx_idx];
    end
  end

  assign mem_we = enter_resp && tx_we && !tx_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[tx_idx] <= tx_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      live_q    <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      live_q    <= live_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: a transaction-level scoreboard predicts every response and its cycle.
module tb_data_mem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned W     = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_tests = 0;
  int n_fails = 0;
  int cyc = 0;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input int act, input int exp);
    n_tests++;
    n_fails++;
    $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
    bit          wr;
    int          idx;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  exp_t        ent;
  logic [31:0] mm [DEPTH];
  bit          outstanding = 0;
  bit          seen = 0;
  bit          rst_hi_prev = 0;
  logic [31:0] m_off;
  int unsigned m_widx;
  bit          m_err;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      q.delete();
      outstanding = 0;
      seen = 0;
      rst_hi_prev = 0;
    end else begin
      check("req_ready", 32'(req_ready), 32'(!outstanding && rst_hi_prev));
      if (rsp_valid) begin
        if (q.size() == 0) begin
          fail_now("rsp_spurious", 1, 0);
        end else begin
          if (!seen) begin
            check("rsp_cycle", 32'(cyc), 32'(q[0].due));
            seen = 1;
            if (q[0].wr) mm[q[0].idx] = q[0].wd;
          end
          check("rsp_rdata", rsp_rdata, q[0].rd);
          check("rsp_err", 32'(rsp_err), 32'(q[0].er));
          if (rsp_ready) begin
            void'(q.pop_front());
            outstanding = 0;
            seen = 0;
          end
        end
      end else if (q.size() > 0 && cyc == q[0].due) begin
        fail_now("rsp_missing", 0, 1);
      end
      if (req_valid && req_ready) begin
        m_off  = req_addr - BASE;
        m_widx = m_off >> 2;
`ifdef DMR_ERR_EN
        m_err = (m_widx >= DEPTH) || (req_addr[1:0] != 2'b00);
`else
        m_err = 0;
`endif
        ent.due = cyc + 1 + int'(W);
        ent.er  = m_err;
        ent.wr  = req_we && !m_err;
        ent.idx = int'(m_widx % DEPTH);
        ent.wd  = req_wdata;
        ent.rd  = req_we ? 32'd0 : (m_err ? 32'hDEAD_BEEF : mm[ent.idx]);
        q.push_back(ent);
        outstanding = 1;
      end
      rst_hi_prev = 1;
    end
  end

  // ---------------- drivers (entered and left at posedge+1) ----------------
  task automatic wait_accept(output int acc);
    bit ok = 0;
    acc = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        acc = cyc;
      end
    end
    if (!ok) fail_now("accept_timeout", 0, 1);
  endtask

  task automatic collect(input int hold, output logic [31:0] rd, output logic er, output int first);
    bit ok = 0;
    rd = '0;
    er = 1'b0;
    first = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        first = cyc;
        rd = rsp_rdata;
        er = rsp_err;
      end
    end
    if (!ok) begin
      fail_now("rsp_timeout", 0, 1);
      @(posedge clk); #1;
      rsp_ready = 0;
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1;
    end
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er, output int acc, output int lat);
    int first;
    req_valid = 1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    wait_accept(acc);
    @(posedge clk); #1;
    req_valid = 0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    collect(hold, rd, er, first);
    lat = first - acc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          acc, lat, prev, first, acc_b;
    logic [31:0] a;
    int          sel;

    reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // basic write then read with fixed latency
    txn(1, 32'h10, 32'h1234_5678, 0, rd, er, acc, lat);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_rdata", rd, 32'd0);
    check("wr_err", 32'(er), 32'd0);
    txn(0, 32'h10, 32'h0, 0, rd, er, acc, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rd, 32'h1234_5678);
    check("rd_err", 32'(er), 32'd0);

    // backpressure for 5 cycles with a second request held waiting
    req_valid = 1; req_we = 0; req_addr = 32'h10; req_wdata = 0; rsp_ready = 0;
    wait_accept(acc);
    @(posedge clk); #1;
    req_we = 1; req_addr = 32'h14; req_wdata = 32'h0BAD_CAFE;
    collect(5, rd, er, first);
    check("bp_rdata", rd, 32'h1234_5678);
    wait_accept(acc_b);
    check("bp_second_accept", 32'(acc_b), 32'(first + 6));
    @(posedge clk); #1;
    req_valid = 0;
    rsp_ready = 1;
    collect(0, rd, er, first);
    txn(0, 32'h14, 32'h0, 2, rd, er, acc, lat);
    check("bp_second_write", rd, 32'h0BAD_CAFE);

    // fill the whole scratchpad back-to-back; each access takes W+2 cycles
    prev = -1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      txn(1, BASE + 32'(i * 4), $urandom, 0, rd, er, acc, lat);
      if (i > 0) check("throughput", 32'(acc - prev), 32'(W + 2));
      prev = acc;
    end

    // out-of-range and misaligned accesses
    txn(1, 32'h0, 32'hCAFE_F00D, 0, rd, er, acc, lat);
    txn(0, 32'h400, 32'h0, 1, rd, er, acc, lat);
`ifdef DMR_ERR_EN
    check("oor_rd_rdata", rd, 32'hDEAD_BEEF);
    check("oor_rd_err", 32'(er), 32'd1);
`else
    check("oor_rd_rdata", rd, 32'hCAFE_F00D);
    check("oor_rd_err", 32'(er), 32'd0);
`endif
    txn(1, 32'h402, 32'h0000_1111, 0, rd, er, acc, lat);
`ifdef DMR_ERR_EN
    check("mis_wr_err", 32'(er), 32'd1);
`else
    check("mis_wr_err", 32'(er), 32'd0);
`endif
    txn(0, 32'h0, 32'h0, 0, rd, er, acc, lat);
`ifdef DMR_ERR_EN
    check("word0_after_mis_wr", rd, 32'hCAFE_F00D);
`else
    check("word0_after_mis_wr", rd, 32'h0000_1111);
`endif

    // reset during the wait states of a write drops it
    txn(1, 32'h20, 32'hA5A5_A5A5, 0, rd, er, acc, lat);
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hFFFF_0000; rsp_ready = 1;
    wait_accept(acc);
    @(posedge clk); #1;
    req_valid = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) sel = 1;
    end
    check("rst_drop_no_rsp", 32'(sel), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 0;
    txn(0, 32'h20, 32'h0, 0, rd, er, acc, lat);
    check("rst_drop_old_value", rd, 32'hA5A5_A5A5);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      else               a = BASE + 32'($urandom_range(0, 255)) * 4;
      txn(1'($urandom), a, $urandom, int'($urandom_range(0, 3)), rd, er, acc, lat);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end
endmodule
